axi_burst_beat_gen: RTL and testbench
=====================================

Name: axi_burst_beat_gen

Overview:
- Expands one accepted AXI AW/AR address beat into the per-beat address sequence for FIXED, INCR and WRAP bursts.
- Sits directly downstream of the channel types and burst constants of the shared AXI package.
- Consumed by memory/peripheral slaves and by width converters that need an explicit address for every data beat.
- Also flags protocol-illegal bursts so the consumer can return RESP_SLVERR.

Parameters:
- AddrWidth, 64, address width in bits.
- DataWidth, 64, bus data width in bits; max legal size = log2(DataWidth/8).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- ax_valid_i  in  1  burst request valid.
- ax_ready_o  out  1  burst request accepted.
- ax_addr_i  in  AddrWidth  start address.
- ax_len_i  in  8 (len_t)  beats minus one.
- ax_size_i  in  3 (size_t)  log2 bytes per beat.
- ax_burst_i  in  2 (burst_t)  burst type.
- beat_valid_o  out  1  beat valid.
- beat_ready_i  in  1  beat consumed.
- beat_addr_o  out  AddrWidth  beat address.
- beat_idx_o  out  8  beat number, 0..len.
- beat_last_o  out  1  final beat of burst.
- beat_err_o  out  1  burst illegal; constant for the whole burst.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: FSM enters IDLE; beat_valid_o=0; beat_addr_o=0; beat_idx_o=0; beat_last_o=0; beat_err_o=0.
- Reset mid-burst: the burst is abandoned and no further beats are emitted.
- FSM states: IDLE, BURST.
- ax_ready_o = (state==IDLE) | (beat_valid_o & beat_ready_i & beat_last_o). The second term gives back-to-back bursts with no bubble and is a combinational path from beat_ready_i.
- On an ax handshake: latch addr, len, size, burst and err; go to BURST. Beat 0 is valid the next cycle (latency 1).
- beat_valid_o=1 throughout BURST.
- Beat handshake with beat_last_o=0: beat_idx_o increments and beat_addr_o advances.
- Beat handshake with beat_last_o=1: return to IDLE, unless a new ax handshakes in the same cycle, in which case reload and stay in BURST.
- Beat outputs hold stable while beat_valid_o & !beat_ready_i (AXI stability rule).
- beat_last_o = (beat_idx_o == latched len).
- Address arithmetic: nbytes = 1<<size; aligned = addr & ~(nbytes-1). All address arithmetic is mod 2^AddrWidth.
- FIXED: every beat address = ax_addr_i.
- INCR: beat0 = ax_addr_i, which may be unaligned. Beat n = aligned + n*nbytes.
- WRAP: wsize = (len+1)*nbytes; lower = addr & ~(wsize-1); next = cur + nbytes. If next == lower+wsize, next = lower.
- Error conditions; any one sets err:
  - burst==2'b11 (reserved);
  - size > log2(DataWidth/8);
  - WRAP with len not in {1,3,7,15};
  - WRAP with unaligned addr;
  - INCR crossing a 4 KiB boundary, i.e. aligned[AddrWidth-1:12] != (aligned + len*nbytes)[AddrWidth-1:12];
  - FIXED with len > 15.
- On error: all len+1 beats are still emitted (the consumer must drain the W data). Addresses follow INCR rules, or FIXED rules if burst==FIXED. beat_err_o=1 on every beat.
- ax_len_i=0: a single beat with beat_last_o=1 on beat 0.
- ax_len_i=255 INCR: 256 beats; beat_idx_o reaches 255 without overflow.

Decomposition:
- Add to the shared AXI package: BURST_RESERVED=2'b11 constant.
- Add to the shared AXI package these pure functions:
  - num_bytes(size_t);
  - aligned_addr(addr, size);
  - wrap_boundary(addr, len, size);
  - beat_addr(addr, len, size, burst, idx).
- The functions are reusable by downstream slaves and checkers.
- No sub-module: a single FSM plus an address register. Legality checking is combinational logic in the module.

Test Plan:
- INCR, addr=0x1004, len=3, size=2 (64b bus) -> beats 0x1004, 0x1008, 0x100C, 0x1010; last on idx 3; err=0.
- WRAP, addr=0x38, len=3, size=3 -> beats 0x38, 0x20, 0x28, 0x30; err=0. Then WRAP with addr=0x3C -> err=1 on all 4 beats.
- FIXED, addr=0x80, len=7, with beat_ready_i toggling 1010... -> 8 beats all at 0x80; outputs stable on stalled cycles.
- INCR, addr=0xFF8, len=1, size=3 -> beats 0xFF8, 0x1000 with err=1. Also burst=2'b11 -> err=1.
- Back-to-back: second ax_valid_i held during the last beat of burst A -> ax_ready_o=1 in the last-beat cycle; burst B beat 0 appears the next cycle with no idle gap.
- rst_i asserted at beat 2 of a len=7 burst -> the next cycle beat_valid_o=0 and ax_ready_o=1; a fresh burst starts at idx 0.

Source files
------------

// File: rtl/axi_burst_beat_gen_pkg.sv
// rtl/axi_burst_beat_gen_pkg.sv - AXI burst types, constants and per-beat address helpers
package axi_burst_beat_gen_pkg;

    localparam int unsigned MaxAddrWidth = 64;
    localparam int unsigned PageBits     = 12;

    typedef logic [MaxAddrWidth-1:0] addr_t;
    typedef logic [7:0]              len_t;
    typedef logic [2:0]              size_t;
    typedef logic [1:0]              burst_t;

    localparam burst_t BURST_FIXED    = 2'b00;
    localparam burst_t BURST_INCR     = 2'b01;
    localparam burst_t BURST_WRAP     = 2'b10;
    localparam burst_t BURST_RESERVED = 2'b11;

    function automatic addr_t num_bytes(input size_t size);
        return addr_t'(1) << size;
    endfunction

    function automatic addr_t aligned_addr(input addr_t addr, input size_t size);
        return addr & ~(num_bytes(size) - addr_t'(1));
    endfunction

    function automatic addr_t wrap_bytes(input len_t len, input size_t size);
        return (addr_t'(len) + addr_t'(1)) << size;
    endfunction

    function automatic addr_t wrap_boundary(input addr_t addr, input len_t len, input size_t size);
        return addr & ~(wrap_bytes(len, size) - addr_t'(1));
    endfunction

    function automatic logic legal_wrap_len(input len_t len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Closed-form address of beat idx; WRAP assumes a legal (aligned, power-of-two) burst.
    function automatic addr_t beat_addr(input addr_t addr, input len_t len, input size_t size,
                                        input burst_t burst, input len_t idx);
        addr_t off;
        addr_t lower;
        addr_t res;
        off = addr_t'(idx) << size;
        case (burst)
            BURST_FIXED: res = addr;
            BURST_WRAP: begin
                lower = wrap_boundary(addr, len, size);
                res   = lower + ((addr + off) & (wrap_bytes(len, size) - addr_t'(1)));
            end
            default: res = (idx == 8'd0) ? addr : aligned_addr(addr, size) + off;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/axi_burst_beat_gen_if.sv
// rtl/axi_burst_beat_gen_if.sv - burst request and beat stream bundle for the beat generator
interface axi_burst_beat_gen_if
    import axi_burst_beat_gen_pkg::*;
#(
    parameter int unsigned AddrWidth = 64
);
    logic                 ax_valid_i;
    logic                 ax_ready_o;
    logic [AddrWidth-1:0] ax_addr_i;
    len_t                 ax_len_i;
    size_t                ax_size_i;
    burst_t               ax_burst_i;
    logic                 beat_valid_o;
    logic                 beat_ready_i;
    logic [AddrWidth-1:0] beat_addr_o;
    len_t                 beat_idx_o;
    logic                 beat_last_o;
    logic                 beat_err_o;

    modport slave (
        input  ax_valid_i, ax_addr_i, ax_len_i, ax_size_i, ax_burst_i, beat_ready_i,
        output ax_ready_o, beat_valid_o, beat_addr_o, beat_idx_o, beat_last_o, beat_err_o
    );

    modport master (
        output ax_valid_i, ax_addr_i, ax_len_i, ax_size_i, ax_burst_i, beat_ready_i,
        input  ax_ready_o, beat_valid_o, beat_addr_o, beat_idx_o, beat_last_o, beat_err_o
    );
endinterface

// File: rtl/axi_burst_beat_gen.sv
// rtl/axi_burst_beat_gen.sv - expands one AXI address beat into per-beat addresses with legality flag
module axi_burst_beat_gen
    import axi_burst_beat_gen_pkg::*;
#(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64
) (
    input logic                 clk_i,
    input logic                 rst_i,
    axi_burst_beat_gen_if.slave bus
);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] BURST   = 1'b1;
    localparam size_t      MaxSize = size_t'($clog2(DataWidth / 8));

    logic [0:0]           state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d, base_q, base_d;
    len_t                 idx_q, idx_d, len_q, len_d;
    size_t                size_q, size_d;
    burst_t               burst_q, burst_d;
    logic                 err_q, err_d;

    logic                 beat_valid, beat_last, beat_hs, ax_ready, ax_hs;
    addr_t                ax_addr, ax_aligned;
    logic [AddrWidth-1:0] page_lo, page_hi;
    logic                 err_rsvd, err_size, err_wrap, err_incr, err_fixed, ax_err;
    burst_t               ax_eff_burst;

    assign beat_valid = (state_q == BURST);
    assign beat_last  = beat_valid && (idx_q == len_q);
    assign beat_hs    = beat_valid && bus.beat_ready_i;
    // Accepting during the last beat handshake keeps back-to-back bursts bubble-free.
    assign ax_ready   = (state_q == IDLE) || (beat_hs && beat_last);
    assign ax_hs      = bus.ax_valid_i && ax_ready;

    assign bus.ax_ready_o   = ax_ready;
    assign bus.beat_valid_o = beat_valid;
    assign bus.beat_addr_o  = addr_q;
    assign bus.beat_idx_o   = idx_q;
    assign bus.beat_last_o  = beat_last;
    assign bus.beat_err_o   = beat_valid && err_q;

    always_comb begin
        ax_addr    = addr_t'(bus.ax_addr_i);
        ax_aligned = aligned_addr(ax_addr, bus.ax_size_i);
        page_lo    = AddrWidth'(ax_aligned);
        page_hi    = AddrWidth'(ax_aligned + (addr_t'(bus.ax_len_i) << bus.ax_size_i));
        err_rsvd   = (bus.ax_burst_i == BURST_RESERVED);
        err_size   = (bus.ax_size_i > MaxSize);
        err_wrap   = (bus.ax_burst_i == BURST_WRAP) &&
                     (!legal_wrap_len(bus.ax_len_i) || (ax_aligned != ax_addr));
        err_incr   = (bus.ax_burst_i == BURST_INCR) && (((page_lo ^ page_hi) >> PageBits) != '0);
        err_fixed  = (bus.ax_burst_i == BURST_FIXED) && (bus.ax_len_i > 8'd15);
        ax_err     = err_rsvd || err_size || err_wrap || err_incr || err_fixed;
        // Illegal bursts still drain len+1 beats, walking addresses as INCR unless FIXED.
        if (!ax_err) begin
            ax_eff_burst = bus.ax_burst_i;
        end else if (bus.ax_burst_i == BURST_FIXED) begin
            ax_eff_burst = BURST_FIXED;
        end else begin
            ax_eff_burst = BURST_INCR;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        base_d  = base_q;
        idx_d   = idx_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        err_d   = err_q;
        if (ax_hs) begin
            state_d = BURST;
            addr_d  = bus.ax_addr_i;
            base_d  = bus.ax_addr_i;
            idx_d   = '0;
            len_d   = bus.ax_len_i;
            size_d  = bus.ax_size_i;
            burst_d = ax_eff_burst;
            err_d   = ax_err;
        end else if (beat_hs) begin
            if (beat_last) begin
                state_d = IDLE;
            end else begin
                idx_d  = idx_q + 8'd1;
                addr_d = AddrWidth'(beat_addr(addr_t'(base_q), len_q, size_q, burst_q, idx_d));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= BURST_FIXED;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_burst_beat_gen.sv
// tb/tb_axi_burst_beat_gen.sv - self-checking bench for axi_burst_beat_gen
module tb_axi_burst_beat_gen;
    import axi_burst_beat_gen_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_burst_beat_gen_if #(.AddrWidth(64)) bus ();
    axi_burst_beat_gen #(.AddrWidth(64), .DataWidth(64)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0]       addr;
        int                len;
        int                size;
        int                burst;
        int                mode;
        bit                err;
        logic [7:0][63:0]  exp;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit model_err(input logic [63:0] a, input int len, input int size, input int burst);
        logic [63:0] nb;
        logic [63:0] al;
        bit e;
        nb = 64'd1 << size;
        al = a - (a % nb);
        e  = 1'b0;
        if (burst == 3) e = 1'b1;
        if (size > 3) e = 1'b1;
        if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) e = 1'b1;
        if (burst == 2 && (a % nb) != 64'd0) e = 1'b1;
        if (burst == 1 && (al / 64'd4096) != ((al + nb * 64'(len)) / 64'd4096)) e = 1'b1;
        if (burst == 0 && len > 15) e = 1'b1;
        return e;
    endfunction

    function automatic logic [63:0] model_addr(input logic [63:0] a, input int len, input int size,
                                               input int burst, input int n, input bit err);
        logic [63:0] nb;
        logic [63:0] ws;
        logic [63:0] lower;
        nb = 64'd1 << size;
        if (burst == 0) return a;
        if (burst == 2 && !err) begin
            ws    = nb * 64'(len + 1);
            lower = a - (a % ws);
            return lower + ((a - lower + nb * 64'(n)) % ws);
        end
        if (n == 0) return a;
        return a - (a % nb) + nb * 64'(n);
    endfunction

    task automatic drive_ax(input logic [63:0] a, input int len, input int size, input int burst);
        bus.ax_valid_i = 1'b1;
        bus.ax_addr_i  = a;
        bus.ax_len_i   = 8'(len);
        bus.ax_size_i  = 3'(size);
        bus.ax_burst_i = 2'(burst);
    endtask

    // mode: 0 = always ready, 1 = ready toggles 1010..., 2 = random ready
    task automatic run_burst(input logic [63:0] a, input int len, input int size, input int burst,
                             input logic [63:0] exp_a[$], input bit exp_err, input int mode);
        int guard;
        int n;
        bit tog;
        bit br;
        @(negedge clk);
        drive_ax(a, len, size, burst);
        bus.beat_ready_i = 1'b0;
        #1;
        guard = 0;
        while (!bus.ax_ready_o && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk("ax_ready_idle", 64'(bus.ax_ready_o), 64'd1);
        n     = 0;
        tog   = 1'b1;
        guard = 0;
        while (n <= len && guard < 4000) begin
            @(negedge clk);
            bus.ax_valid_i = 1'b0;
            if (mode == 0) br = 1'b1;
            else if (mode == 1) br = tog;
            else br = 1'($urandom_range(0, 1));
            tog = !tog;
            bus.beat_ready_i = br;
            #1;
            chk("beat_valid", 64'(bus.beat_valid_o), 64'd1);
            chk("beat_addr", bus.beat_addr_o, exp_a[n]);
            chk("beat_idx", 64'(bus.beat_idx_o), 64'(n));
            chk("beat_last", 64'(bus.beat_last_o), 64'(n == len));
            chk("beat_err", 64'(bus.beat_err_o), 64'(exp_err));
            if (br) n++;
            guard++;
        end
        chk("burst_beats", 64'(n), 64'(len + 1));
        @(negedge clk);
        bus.beat_ready_i = 1'b0;
        #1;
        chk("post_burst_idle", 64'(bus.beat_valid_o), 64'd0);
    endtask

    task automatic run_model(input logic [63:0] a, input int len, input int size, input int burst, input int mode);
        logic [63:0] q[$];
        bit e;
        e = model_err(a, len, size, burst);
        q = {};
        for (int i = 0; i <= len; i++) q.push_back(model_addr(a, len, size, burst, i, e));
        run_burst(a, len, size, burst, q, e, mode);
    endtask

    task automatic add_vec(input logic [63:0] a, input int len, input int size, input int burst,
                           input int mode, input bit err,
                           input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] e2,
                           input logic [63:0] e3);
        vec_t v;
        v.addr = a; v.len = len; v.size = size; v.burst = burst; v.mode = mode; v.err = err;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        for (int i = 4; i < 8; i++) v.exp[i] = e0;
        tbl.push_back(v);
    endtask

    initial begin
        logic [63:0] q[$];
        logic [63:0] a;
        int len;
        int size;
        int burst;

        rst = 1'b1;
        bus.ax_valid_i = 1'b0; bus.ax_addr_i = '0; bus.ax_len_i = '0;
        bus.ax_size_i = '0; bus.ax_burst_i = '0; bus.beat_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.beat_valid_o), 64'd0);
        chk("rst_addr", bus.beat_addr_o, 64'd0);
        chk("rst_idx", 64'(bus.beat_idx_o), 64'd0);
        chk("rst_last", 64'(bus.beat_last_o), 64'd0);
        chk("rst_err", 64'(bus.beat_err_o), 64'd0);
        chk("rst_ax_ready", 64'(bus.ax_ready_o), 64'd1);

        add_vec(64'h1004, 3, 2, 1, 0, 1'b0, 64'h1004, 64'h1008, 64'h100C, 64'h1010);
        add_vec(64'h38,   3, 3, 2, 2, 1'b0, 64'h38,   64'h20,   64'h28,   64'h30);
        add_vec(64'h3C,   3, 3, 2, 0, 1'b1, 64'h3C,   64'h40,   64'h48,   64'h50);
        add_vec(64'h80,   7, 3, 0, 1, 1'b0, 64'h80,   64'h80,   64'h80,   64'h80);
        add_vec(64'hFF8,  1, 3, 1, 0, 1'b1, 64'hFF8,  64'h1000, 64'h0,    64'h0);
        add_vec(64'h100,  1, 2, 3, 0, 1'b1, 64'h100,  64'h104,  64'h0,    64'h0);
        add_vec(64'h40,   0, 3, 1, 0, 1'b0, 64'h40,   64'h0,    64'h0,    64'h0);
        add_vec(64'h0,    1, 4, 1, 2, 1'b1, 64'h0,    64'h10,   64'h0,    64'h0);
        add_vec(64'h0,    2, 2, 2, 0, 1'b1, 64'h0,    64'h4,    64'h8,    64'h0);
        add_vec(64'h4,    1, 2, 2, 1, 1'b0, 64'h4,    64'h0,    64'h0,    64'h0);
        add_vec(64'h7,    2, 1, 0, 2, 1'b0, 64'h7,    64'h7,    64'h7,    64'h0);
        add_vec(64'hFFF,  1, 0, 1, 0, 1'b1, 64'hFFF,  64'h1000, 64'h0,    64'h0);
        add_vec(64'hFFC,  0, 3, 1, 0, 1'b0, 64'hFFC,  64'h0,    64'h0,    64'h0);
        foreach (tbl[k]) begin
            q = {};
            for (int i = 0; i <= tbl[k].len; i++) q.push_back(tbl[k].exp[i]);
            run_burst(tbl[k].addr, tbl[k].len, tbl[k].size, tbl[k].burst, q, tbl[k].err, tbl[k].mode);
        end

        run_model(64'h200, 16, 2, 0, 0);
        run_model(64'h0, 255, 0, 1, 0);

        // Back-to-back: burst B is accepted in the last-beat cycle of burst A.
        @(negedge clk);
        drive_ax(64'h0, 1, 3, 1);
        bus.beat_ready_i = 1'b0;
        #1;
        chk("b2b_a_accept", 64'(bus.ax_ready_o), 64'd1);
        @(negedge clk);
        bus.ax_valid_i = 1'b0;
        bus.beat_ready_i = 1'b1;
        #1;
        chk("b2b_a_beat0", bus.beat_addr_o, 64'h0);
        @(negedge clk);
        drive_ax(64'h200, 0, 3, 1);
        #1;
        chk("b2b_a_last", 64'(bus.beat_last_o), 64'd1);
        chk("b2b_a_beat1", bus.beat_addr_o, 64'h8);
        chk("b2b_ax_ready", 64'(bus.ax_ready_o), 64'd1);
        @(negedge clk);
        bus.ax_valid_i = 1'b0;
        #1;
        chk("b2b_b_valid", 64'(bus.beat_valid_o), 64'd1);
        chk("b2b_b_addr", bus.beat_addr_o, 64'h200);
        chk("b2b_b_idx", 64'(bus.beat_idx_o), 64'd0);
        chk("b2b_b_last", 64'(bus.beat_last_o), 64'd1);
        @(negedge clk);
        bus.beat_ready_i = 1'b0;
        #1;
        chk("b2b_idle", 64'(bus.beat_valid_o), 64'd0);

        // Reset at beat 2 of a len=7 burst abandons it.
        @(negedge clk);
        drive_ax(64'h0, 7, 3, 1);
        #1;
        @(negedge clk);
        bus.ax_valid_i = 1'b0;
        bus.beat_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.beat_ready_i = 1'b0;
        #1;
        chk("mid_rst_idx2", 64'(bus.beat_idx_o), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.beat_valid_o), 64'd0);
        chk("mid_rst_ax_ready", 64'(bus.ax_ready_o), 64'd1);
        chk("mid_rst_idx", 64'(bus.beat_idx_o), 64'd0);
        run_model(64'h3000, 3, 3, 1, 0);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 2))
                0: a = {$urandom, $urandom};
                1: a = 64'hFC0 + 64'($urandom_range(0, 63));
                default: a = 64'($urandom_range(0, 255));
            endcase
            size  = $urandom_range(0, 4);
            burst = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) len = $urandom_range(0, 255);
            else len = $urandom_range(0, 16);
            if (burst == 2 && $urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 3))
                    0: len = 1;
                    1: len = 3;
                    2: len = 7;
                    default: len = 15;
                endcase
                a = a & ~((64'd1 << size) - 64'd1);
            end
            run_model(a, len, size, burst, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
